// File: rtl/key_pkg.sv
// key_pkg: shared types and helpers for the keypad key decoder.
//   - state_t     : debounce FSM states
//   - KEY_CODE_W, ROW_W, COL_W : field widths of the key code
//   - row_index() : lowest-numbered low row of an active-low row vector
package key_pkg;

  localparam int KEY_CODE_W = 4;
  localparam int ROW_W      = 4;
  localparam int COL_W      = 2;

  typedef enum logic [1:0] {
    IDLE,
    DB_PRESS,
    HELD,
    DB_RELEASE
  } state_t;

  // Lowest index wins when several rows are low; an all-ones vector maps to 0
  // (never used, because a capture only happens while some row is low).
  function automatic logic [1:0] row_index(input logic [ROW_W-1:0] rows_n);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = ROW_W - 1; i >= 0; i--) begin
      if (!rows_n[i]) idx = 2'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: parameterized-width two-flop synchronizer.
// Ports:
//   clk   in        sampling clock
//   rst_n in        asynchronous active-low reset; both stages load RST_VAL
//   d     in  WIDTH asynchronous input
//   q     out WIDTH synchronized output (two clk edges of latency)
module sync_2ff #(
  parameter int               WIDTH   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] r_meta;
  logic [WIDTH-1:0] r_sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_meta <= RST_VAL;
      r_sync <= RST_VAL;
    end else begin
      r_meta <= d;
      r_sync <= r_meta;
    end
  end

  assign q = r_sync;

endmodule

// File: rtl/key_decoder.sv
// key_decoder: debounces keypad presses/releases seen on the raw row lines,
// turns a confirmed press into a 4-bit key code and offers it to the host
// through a one-entry valid/ack buffer.
// Ports:
//   clk       in     system clock, rising edge
//   rst_n     in     asynchronous active-low reset
//   rows      in  4  raw row lines, active low (all ones = no key)
//   col_idx   in  2  scanner column counter, frozen while a key is down
//   key_code  out 4  {row_index, col_idx} of the last accepted key
//   key_valid out 1  key_code holds an unacknowledged key
//   key_ack   in  1  host consumes key_code
//   overrun   out 1  one-cycle pulse: a press was confirmed but dropped
module key_decoder
  import key_pkg::*;
#(
  parameter  int DEBOUNCE_CYCLES = 16,
  localparam int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ROW_W-1:0]      rows,
  input  logic [COL_W-1:0]      col_idx,
  output logic [KEY_CODE_W-1:0] key_code,
  output logic                  key_valid,
  input  logic                  key_ack,
  output logic                  overrun
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [ROW_W-1:0]      w_rows_s;
  logic                  w_press_s;
  state_t                r_state;
  state_t                w_state_next;
  logic [CNT_W-1:0]      r_cnt;
  logic [CNT_W-1:0]      w_cnt_next;
  logic                  w_capture;
  logic [KEY_CODE_W-1:0] r_key_code;
  logic                  r_key_valid;
  logic                  r_overrun;

  sync_2ff #(
    .WIDTH   (ROW_W),
    .RST_VAL (4'b1111)
  ) u_row_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (rows),
    .q     (w_rows_s)
  );

  assign w_press_s = ~&w_rows_s;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_capture    = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_press_s) begin
          w_state_next = DB_PRESS;
          w_cnt_next   = '0;
        end
      end
      DB_PRESS: begin
        if (!w_press_s) begin
          w_state_next = IDLE;
        end else if (r_cnt == CNT_LAST) begin
          w_capture    = 1'b1;
          w_state_next = HELD;
        end else begin
          w_cnt_next = r_cnt + CNT_W'(1);
        end
      end
      HELD: begin
        // No auto-repeat: only a fully debounced release re-arms capture.
        if (!w_press_s) begin
          w_state_next = DB_RELEASE;
          w_cnt_next   = '0;
        end
      end
      DB_RELEASE: begin
        if (w_press_s) begin
          w_state_next = HELD;
        end else if (r_cnt == CNT_LAST) begin
          w_state_next = IDLE;
        end else begin
          w_cnt_next = r_cnt + CNT_W'(1);
        end
      end
      default: begin
        w_state_next = IDLE;
        w_cnt_next   = '0;
      end
    endcase
  end

  // col_idx is taken unsynchronized: the scanner has frozen it for many
  // cycles before a capture can happen, so it is quasi-static here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_key_code  <= '0;
      r_key_valid <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_overrun <= 1'b0;
      if (w_capture) begin
        // An ack in the capture cycle frees the buffer for the new key.
        if (!r_key_valid || key_ack) begin
          r_key_code  <= {row_index(w_rows_s), col_idx};
          r_key_valid <= 1'b1;
        end else begin
          r_overrun <= 1'b1;
        end
      end else if (key_ack && r_key_valid) begin
        r_key_valid <= 1'b0;
      end
    end
  end

  assign key_code  = r_key_code;
  assign key_valid = r_key_valid;
  assign overrun   = r_overrun;

endmodule

// File: tb/tb_key_decoder.sv
module tb_key_decoder;

  logic       clk;
  logic       rst_n;
  logic [3:0] rows;
  logic [1:0] col_idx;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_ack;
  logic       overrun;

  key_decoder #(.DEBOUNCE_CYCLES(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rows      (rows),
    .col_idx   (col_idx),
    .key_code  (key_code),
    .key_valid (key_valid),
    .key_ack   (key_ack),
    .overrun   (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] rows;
    logic [1:0] col;
    logic       ack;
    logic [3:0] code;
    logic       valid;
    logic       ovr;
  } vec_t;

  vec_t vecs[128];
  int   nv;
  int   n_cmp;
  int   n_mis;

  task automatic add(input logic [3:0] r, input logic [1:0] c, input logic a,
                     input logic [3:0] ec, input logic ev, input logic eo,
                     input int n);
    for (int i = 0; i < n; i++) begin
      vecs[nv] = '{rows: r, col: c, ack: a, code: ec, valid: ev, ovr: eo};
      nv++;
    end
  endtask

  task automatic chk(input string name, input logic [3:0] ec, input logic ev,
                     input logic eo);
    n_cmp++;
    if (key_code !== ec || key_valid !== ev || overrun !== eo) begin
      n_mis++;
      $display("FAIL %s: got code=%h valid=%b ovr=%b, expected code=%h valid=%b ovr=%b",
               name, key_code, key_valid, overrun, ec, ev, eo);
    end else begin
      $display("ok   %s: code=%h valid=%b ovr=%b", name, key_code, key_valid, overrun);
    end
  endtask

  // Apply inputs, then sample 1 ns after the next rising edge.
  task automatic step(input logic [3:0] r, input logic [1:0] c, input logic a);
    rows    = r;
    col_idx = c;
    key_ack = a;
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_cmp   = 0;
    n_mis   = 0;
    nv      = 0;
    rst_n   = 1'b0;
    rows    = 4'hF;
    col_idx = 2'd0;
    key_ack = 1'b0;

    // Vector i is sampled after edge i (edge 0 = first edge after reset).
    // With DEBOUNCE_CYCLES=4, rows low from vector k is captured at edge k+6.
    add(4'hF, 2'd0, 1'b0, 4'h0, 1'b0, 1'b0, 2);   // 0-1   idle
    add(4'hD, 2'd2, 1'b0, 4'h0, 1'b0, 1'b0, 6);   // 2-7   clean press debouncing
    add(4'hD, 2'd2, 1'b0, 4'h6, 1'b1, 1'b0, 4);   // 8-11  captured 0x6
    add(4'hF, 2'd2, 1'b0, 4'h6, 1'b1, 1'b0, 8);   // 12-19 release
    add(4'h7, 2'd1, 1'b0, 4'h6, 1'b1, 1'b0, 6);   // 20-25 second press, no ack
    add(4'h7, 2'd1, 1'b0, 4'h6, 1'b1, 1'b1, 1);   // 26    overrun pulse
    add(4'h7, 2'd1, 1'b0, 4'h6, 1'b1, 1'b0, 1);   // 27    pulse gone
    add(4'h7, 2'd1, 1'b1, 4'h6, 1'b0, 1'b0, 1);   // 28    ack while held
    add(4'h7, 2'd1, 1'b0, 4'h6, 1'b0, 1'b0, 2);   // 29-30 held, no re-capture
    add(4'hF, 2'd1, 1'b0, 4'h6, 1'b0, 1'b0, 3);   // 31-33 short release bounce
    add(4'h7, 2'd1, 1'b0, 4'h6, 1'b0, 1'b0, 4);   // 34-37 back to held, no key
    add(4'hF, 2'd1, 1'b0, 4'h6, 1'b0, 1'b0, 8);   // 38-45 full release
    add(4'hB, 2'd3, 1'b0, 4'h6, 1'b0, 1'b0, 6);   // 46-51 press 1011/col3
    add(4'hB, 2'd3, 1'b0, 4'hB, 1'b1, 1'b0, 4);   // 52-55 captured 0xB
    add(4'hF, 2'd3, 1'b0, 4'hB, 1'b1, 1'b0, 8);   // 56-63 release
    add(4'h7, 2'd1, 1'b0, 4'hB, 1'b1, 1'b0, 6);   // 64-69 press 0111/col1
    add(4'h7, 2'd1, 1'b1, 4'hD, 1'b1, 1'b0, 1);   // 70    ack + capture same edge
    add(4'h7, 2'd1, 1'b0, 4'hD, 1'b1, 1'b0, 3);   // 71-73
    add(4'hF, 2'd1, 1'b0, 4'hD, 1'b1, 1'b0, 8);   // 74-81 release

    @(posedge clk);
    @(posedge clk);
    #1;
    chk("reset", 4'h0, 1'b0, 1'b0);
    #2 rst_n = 1'b1;

    for (int i = 0; i < nv; i++) begin
      step(vecs[i].rows, vecs[i].col, vecs[i].ack);
      chk($sformatf("vec%0d", i), vecs[i].code, vecs[i].valid, vecs[i].ovr);
    end

    // Clear the buffer, then bounce: low 2, high 1, low 2, high.
    step(4'hF, 2'd0, 1'b1);
    chk("ack_clear", 4'hD, 1'b0, 1'b0);
    step(4'hF, 2'd0, 1'b0);
    chk("ack_ignored_when_empty_pre", 4'hD, 1'b0, 1'b0);
    step(4'hF, 2'd0, 1'b1);
    chk("ack_ignored_when_empty", 4'hD, 1'b0, 1'b0);
    step(4'hE, 2'd0, 1'b0); chk("bounce0", 4'hD, 1'b0, 1'b0);
    step(4'hE, 2'd0, 1'b0); chk("bounce1", 4'hD, 1'b0, 1'b0);
    step(4'hF, 2'd0, 1'b0); chk("bounce2", 4'hD, 1'b0, 1'b0);
    step(4'hE, 2'd0, 1'b0); chk("bounce3", 4'hD, 1'b0, 1'b0);
    step(4'hE, 2'd0, 1'b0); chk("bounce4", 4'hD, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) begin
      step(4'hF, 2'd0, 1'b0);
      chk($sformatf("bounce_tail%0d", i), 4'hD, 1'b0, 1'b0);
    end

    // Glitch boundary: a low pulse exactly DEBOUNCE_CYCLES long is rejected.
    for (int i = 0; i < 4; i++) begin
      step(4'hE, 2'd0, 1'b0);
      chk($sformatf("glitch%0d", i), 4'hD, 1'b0, 1'b0);
    end
    for (int i = 0; i < 6; i++) begin
      step(4'hF, 2'd0, 1'b0);
      chk($sformatf("glitch_tail%0d", i), 4'hD, 1'b0, 1'b0);
    end

    // A clean press right after the bounces must still take exactly 6 edges,
    // which shows the FSM went back to IDLE.
    for (int i = 0; i < 6; i++) begin
      step(4'hE, 2'd0, 1'b0);
      chk($sformatf("press_e_wait%0d", i), 4'hD, 1'b0, 1'b0);
    end
    step(4'hE, 2'd0, 1'b0);
    chk("press_e_capture", 4'h0, 1'b1, 1'b0);
    for (int i = 0; i < 8; i++) begin
      step(4'hF, 2'd0, 1'b0);
      chk($sformatf("release_e%0d", i), 4'h0, 1'b1, 1'b0);
    end

    // Async reset while in DB_PRESS with key_valid=1.
    for (int i = 0; i < 4; i++) begin
      step(4'hD, 2'd2, 1'b0);
      chk($sformatf("pre_reset%0d", i), 4'h0, 1'b1, 1'b0);
    end
    #2 rst_n = 1'b0;
    #1;
    chk("async_reset_immediate", 4'h0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    chk("async_reset_held", 4'h0, 1'b0, 1'b0);
    #2 rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step(4'hD, 2'd2, 1'b0);
      chk($sformatf("post_reset_wait%0d", i), 4'h0, 1'b0, 1'b0);
    end
    step(4'hD, 2'd2, 1'b0);
    chk("post_reset_recapture", 4'h6, 1'b1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_mis);
    $finish;
  end

endmodule
